gray_counter: RTL and testbench

Parametrised synchronous Gray-code up/down counter. It holds its count internally in binary and drives registered Gray and binary outputs, so every Gray output change is exactly one bit. The block supports enable, direction, synchronous load in binary or Gray form, and wrap or saturate at the ends of the range. It is the sequential companion to the team's combinational binary-to-Gray converter, for use as a pointer or position encoder in multi-clock-safe designs.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_counter.sv | 56 +++++
 tb/tb_gray_counter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code conversion helpers and width limit for the gray counter family
package gray_pkg;

    localparam int MAX_NUM = 16;

    function automatic logic [MAX_NUM-1:0] bin2gray(input logic [MAX_NUM-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB downward; zero-extended narrow inputs convert unchanged.
    function automatic logic [MAX_NUM-1:0] gray2bin(input logic [MAX_NUM-1:0] g);
        logic [MAX_NUM-1:0] b;
        b[MAX_NUM-1] = g[MAX_NUM-1];
        for (int i = MAX_NUM - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// gray_counter: up/down Gray-code counter with load, wrap/saturate, registered Gray+binary outputs
//   clk, reset (sync, active-high); en/up step the count; load/ld_val (binary or Gray per LD_GRAY)
//   g_out/b_out registered count; tc combinational wrap/saturation marker; sat registered blocked-step flag
module gray_counter
    import gray_pkg::*;
#(
    parameter int NUM     = 6,
    parameter bit WRAP    = 1'b1,
    parameter bit LD_GRAY = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           up,
    input  logic           load,
    input  logic [NUM-1:0] ld_val,
    output logic [NUM-1:0] g_out,
    output logic [NUM-1:0] b_out,
    output logic           tc,
    output logic           sat
);

    if (NUM < 2 || NUM > MAX_NUM) begin : g_bad_num
        $error("gray_counter: NUM must be in 2..16");
    end

    logic [NUM-1:0] cnt_q, cnt_d, g_q, step, ld_bin;
    logic           sat_q, sat_d, at_end;

    // Modulo arithmetic makes the plain step equal the wrapped value at either end.
    always_comb begin
        at_end = up ? &cnt_q : ~|cnt_q;
        step   = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
        ld_bin = LD_GRAY ? NUM'(gray2bin(MAX_NUM'(ld_val))) : ld_val;
        cnt_d  = load ? ld_bin : !en ? cnt_q : (at_end && !WRAP) ? cnt_q : step;
        sat_d  = load ? 1'b0 : en ? (at_end && !WRAP) : sat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            g_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            g_q   <= NUM'(bin2gray(MAX_NUM'(cnt_d)));
            sat_q <= sat_d;
        end
    end

    assign tc    = en && !load && !reset && at_end;
    assign g_out = g_q;
    assign b_out = cnt_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed self-checking bench for gray_counter (wrap, saturate and Gray-load variants)
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [5:0] ld_val = '0;
    logic [5:0] gw, bw, gs, bs, gg, bg;
    logic       tcw, satw, tcs, sats, tcg, satg;
    int         n_asrt = 0, n_fail = 0;
    logic [5:0] prev_g;

    always #5 clk = ~clk;

    gray_counter #(.NUM(6), .WRAP(1'b1), .LD_GRAY(1'b0)) u_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .ld_val(ld_val),
        .g_out(gw), .b_out(bw), .tc(tcw), .sat(satw));

    gray_counter #(.NUM(6), .WRAP(1'b0), .LD_GRAY(1'b0)) u_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .ld_val(ld_val),
        .g_out(gs), .b_out(bs), .tc(tcs), .sat(sats));

    gray_counter #(.NUM(6), .WRAP(1'b1), .LD_GRAY(1'b1)) u_g (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .ld_val(ld_val),
        .g_out(gg), .b_out(bg), .tc(tcg), .sat(satg));

    function automatic logic [5:0] g2b(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset for two cycles
        tick();
        tick();
        chk("rst_g", gw, 0);
        chk("rst_b", bw, 0);
        chk("rst_sat", satw, 0);
        chk("rst_tc", tcw, 0);
        // up-count from reset
        reset = 1'b0; en = 1'b1; up = 1'b1;
        #1 chk("tc_up_at0", tcw, 0);
        prev_g = gw;
        tick(); chk("up_g1", gw, 6'b000001); chk("up_1bit1", $countones(gw ^ prev_g), 1); prev_g = gw;
        tick(); chk("up_g2", gw, 6'b000011); chk("up_1bit2", $countones(gw ^ prev_g), 1); prev_g = gw;
        tick(); chk("up_g3", gw, 6'b000010); chk("up_1bit3", $countones(gw ^ prev_g), 1); prev_g = gw;
        tick(); chk("up_g4", gw, 6'b000110); chk("up_1bit4", $countones(gw ^ prev_g), 1); prev_g = gw;
        tick(); chk("up_g5", gw, 6'b000111); chk("up_1bit5", $countones(gw ^ prev_g), 1);
        chk("up_b5", bw, 5);
        // hold
        en = 1'b0;
        tick(); chk("hold_b", bw, 5); chk("hold_g", gw, 6'b000111);
        // wrap up / saturate up
        load = 1'b1; ld_val = 6'd63;
        tick(); chk("ld63_b", bw, 63); chk("ld63_g", gw, 6'b100000);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1 chk("tc_top_w", tcw, 1); chk("tc_top_s", tcs, 1);
        tick();
        chk("wrapup_b", bw, 0); chk("wrapup_g", gw, 0); chk("wrapup_sat", satw, 0);
        chk("satup_b", bs, 63); chk("satup_sat", sats, 1);
        // back to zero, then down-step wrap / saturate
        en = 1'b0; reset = 1'b1;
        tick(); chk("rst2_sat_s", sats, 0);
        reset = 1'b0; en = 1'b1; up = 1'b0;
        #1 chk("tc_bot_w", tcw, 1); chk("tc_bot_s", tcs, 1);
        tick();
        chk("wrapdn_b", bw, 63); chk("wrapdn_g", gw, 6'b100000); chk("wrapdn_sat", satw, 0);
        chk("satdn_b", bs, 0); chk("satdn_sat", sats, 1);
        up = 1'b1;
        tick();
        chk("unsat_b", bs, 1); chk("unsat_sat", sats, 0); chk("rewrap_b", bw, 0);
        // load encodings
        en = 1'b0; load = 1'b1; ld_val = 6'b101101;
        tick();
        chk("ldbin_b", bw, 6'b101101); chk("ldbin_g", gw, 6'b111011);
        chk("ldgray_alt_b", bg, 6'b110110);
        ld_val = 6'b111011;
        tick();
        chk("ldgray_b", bg, 6'b101101); chk("ldgray_g", gg, 6'b111011);
        // load beats en at the saturated boundary
        ld_val = 6'd63;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick(); chk("presat_sat", sats, 1);
        load = 1'b1; ld_val = 6'd20;
        #1 chk("ld_en_tc_s", tcs, 0); chk("ld_en_tc_w", tcw, 0);
        tick();
        chk("ld_en_b_s", bs, 20); chk("ld_en_sat_s", sats, 0); chk("ld_en_b_w", bw, 20);
        // reset beats load mid-count
        load = 1'b0;
        tick(); chk("cnt21", bw, 21);
        reset = 1'b1; load = 1'b1; ld_val = 6'd40;
        #1 chk("rst_tc_w", tcw, 0);
        tick();
        chk("rst_ld_b", bw, 0); chk("rst_ld_g", gw, 0); chk("rst_ld_bg", bg, 0);
        // full sweep with wrap back to zero
        reset = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        prev_g = gw;
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk("sweep_b", bw, 32'(i % 64));
            chk("sweep_g2b", bw, g2b(gw));
            chk("sweep_1bit", $countones(gw ^ prev_g), 1);
            prev_g = gw;
        end
        // down sweep across the wrap keeps the single-bit property
        up = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("dn_b", bw, 32'((64 - i) % 64));
            chk("dn_1bit", $countones(gw ^ prev_g), 1);
            prev_g = gw;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
